// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - loadable up/down BCD counter with multiplexed 7-segment scan (optional leading-zero blanking: BCD_SCAN_BLANK_EN)
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            port_cc
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = $clog2(SCAN_DIV);

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Segment pattern {g,f,e,d,c,b,a}, active low
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    logic [4*DIGITS-1:0] load_clamped;
    logic [4*DIGITS-1:0] count_stepped;
    logic                step_wrap;

    logic [PS_W-1:0]     scan_ps;
    logic [IDX_W-1:0]    scan_idx;
    logic                scan_tc;
    logic [IDX_W-1:0]    scan_idx_next;

    logic [3:0]          sel_digit;
    logic [6:0]          seg_next;

    // Load value with any non-decimal nibble clamped to 9
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9)
                load_clamped[4*i +: 4] = 4'd9;
            else
                load_clamped[4*i +: 4] = load_val[4*i +: 4];
        end
    end

    // One decimal step with ripple carry/borrow; a carry out of the top digit is the wrap
    always_comb begin
        logic       chain;
        logic [3:0] d;
        count_stepped = '0;
        chain         = 1'b1;
        d             = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_bcd[4*i +: 4];
            if (!chain) begin
                count_stepped[4*i +: 4] = d;
            end else if (up_dn) begin
                if (d >= 4'd9) begin
                    count_stepped[4*i +: 4] = 4'd0;
                end else begin
                    count_stepped[4*i +: 4] = d + 4'd1;
                    chain = 1'b0;
                end
            end else begin
                if (d == 4'd0) begin
                    count_stepped[4*i +: 4] = 4'd9;
                end else begin
                    count_stepped[4*i +: 4] = d - 4'd1;
                    chain = 1'b0;
                end
            end
        end
        step_wrap = chain;
    end

    // Count register: reset, then load, then enabled tick; wrap is a single-cycle pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_bcd <= '0;
            wrap      <= 1'b0;
        end else if (load) begin
            count_bcd <= load_clamped;
            wrap      <= 1'b0;
        end else if (enable && tick) begin
            count_bcd <= count_stepped;
            wrap      <= step_wrap;
        end else begin
            wrap      <= 1'b0;
        end
    end

    // Next scan position, advancing on prescaler terminal count
    always_comb begin
        scan_tc       = (scan_ps == PS_LAST);
        scan_idx_next = scan_idx;
        if (scan_tc) begin
            if (scan_idx == IDX_LAST)
                scan_idx_next = '0;
            else
                scan_idx_next = scan_idx + IDX_W'(1);
        end
    end

    // Free-running prescaler, scan index and anode select (anode tracks the index it is registered with)
    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_ps  <= '0;
            scan_idx <= '0;
            an       <= ~DIGITS'(1);
        end else begin
            scan_ps  <= scan_tc ? '0 : scan_ps + PS_W'(1);
            scan_idx <= scan_idx_next;
            an       <= ~(DIGITS'(1) << scan_idx_next);
        end
    end

    // Digit currently under scan and its segment pattern
    always_comb begin
        sel_digit = count_bcd[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IDX_W'(i))
                sel_digit = count_bcd[4*i +: 4];
        end
    end

`ifdef BCD_SCAN_BLANK_EN
    logic [DIGITS-1:0] lead_zero;

    // lead_zero[i] is set when digit i and every digit above it are zero; digit 0 is never blanked
    always_comb begin
        logic z;
        z         = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z            = z & (count_bcd[4*i +: 4] == 4'd0);
            lead_zero[i] = z;
        end
        seg_next = seg_code(sel_digit);
        if (scan_idx != '0 && lead_zero[scan_idx])
            seg_next = SEG_BLANK;
    end
`else
    // Every digit is displayed, leading zeros included
    always_comb begin
        seg_next = seg_code(sel_digit);
    end
`endif

    // Registered segment output, one cycle behind index/count
    always_ff @(posedge clock) begin
        if (!reset)
            port_cc <= SEG_ZERO;
        else
            port_cc <= seg_next;
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed self-checking bench for bcd_scan_counter (DIGITS=2, SCAN_DIV=4)
module tb_bcd_scan_counter;

    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;

    logic                clock    = 1'b0;
    logic                reset    = 1'b0;
    logic                enable   = 1'b0;
    logic                tick     = 1'b0;
    logic                up_dn    = 1'b1;
    logic                load     = 1'b0;
    logic [4*DIGITS-1:0] load_val = '0;
    logic [4*DIGITS-1:0] count_bcd;
    logic                wrap;
    logic [DIGITS-1:0]   an;
    logic [6:0]          port_cc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [10];
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic [6:0] exp_blank;
    int         idx_prev;
    bit         found;

    bcd_scan_counter #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .tick      (tick),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .an        (an),
        .port_cc   (port_cc)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [7:0] lv,
                        input logic en, input logic tk, input logic ud);
        reset    = rst;
        load     = ld;
        load_val = lv;
        enable   = en;
        tick     = tk;
        up_dn    = ud;
        @(posedge clock);
        #1;
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef BCD_SCAN_BLANK_EN
        exp_blank = 7'b1111111;
`else
        exp_blank = 7'b1000000;
`endif

        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("rst_count", count_bcd, 8'h00);
        check_eq("rst_wrap", wrap, 1'b0);
        check_eq("rst_an", an, 2'b10);
        check_eq("rst_cc", port_cc, 7'b1000000);

        // Up-count wrap 98 -> 99 -> 00
        step(1'b1, 1'b1, 8'h98, 1'b0, 1'b0, 1'b1);
        check_eq("load_98", count_bcd, 8'h98);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check_eq("up_99", count_bcd, 8'h99);
        check_eq("up_99_wrap", wrap, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check_eq("up_00", count_bcd, 8'h00);
        check_eq("up_00_wrap", wrap, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("idle_wrap_low", wrap, 1'b0);
        check_eq("idle_hold", count_bcd, 8'h00);

        // Down-count wrap 00 -> 99 -> 98
        step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_eq("dn_99", count_bcd, 8'h99);
        check_eq("dn_99_wrap", wrap, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_eq("dn_98", count_bcd, 8'h98);
        check_eq("dn_98_wrap", wrap, 1'b0);

        // Clamp and load priority
        step(1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b1);
        check_eq("clamp_1f", count_bcd, 8'h19);
        step(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
        check_eq("clamp_ab", count_bcd, 8'h99);
        step(1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1'b1);
        check_eq("load_wins", count_bcd, 8'h42);
        check_eq("load_wins_wrap", wrap, 1'b0);

        // Tick without enable is dropped, not queued
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check_eq("tick_no_en", count_bcd, 8'h42);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("no_queue", count_bcd, 8'h42);

        // Mid-range carry and borrow
        step(1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        check_eq("carry_10", count_bcd, 8'h10);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check_eq("borrow_09", count_bcd, 8'h09);

        // Reset wins over load and tick
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        check_eq("rst_prio_count", count_bcd, 8'h00);
        check_eq("rst_prio_wrap", wrap, 1'b0);

        // Scan sequence from a fresh reset; k counts edges since reset
        step(1'b1, 1'b1, 8'h37, 1'b0, 1'b0, 1'b1);
        check_eq("scan_an_k1", an, 2'b10);
        check_eq("scan_cc_k1", port_cc, 7'b1000000);
        for (int k = 2; k <= 17; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            exp_an   = (((k / 4) % 2) == 0) ? 2'b10 : 2'b01;
            idx_prev = ((k - 1) / 4) % 2;
            exp_seg  = (idx_prev == 0) ? seg_tab[7] : seg_tab[3];
            check_eq($sformatf("scan_an_k%0d", k), an, exp_an);
            check_eq($sformatf("scan_cc_k%0d", k), port_cc, exp_seg);
        end

        // Leading-zero display of 05
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
        found = 1'b0;
        for (int t = 0; t < 12 && !found; t++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            if (an == 2'b01) found = 1'b1;
        end
        check_eq("blank_wait_an01", found, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("digit1_of_05", port_cc, exp_blank);
        for (int t = 0; t < 4; t++)
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_eq("digit0_an", an, 2'b10);
        check_eq("digit0_of_05", port_cc, seg_tab[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of BCD digits and display positions (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, meaning the clock cycles per display position (legal >=2).
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: count enable.
REQ-006 SHALL have port tick, input, 1 bit: one-cycle count strobe.
REQ-007 SHALL have port up_dn, input, 1 bit: count direction, 1=up, 0=down.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, 4*DIGITS bits: BCD load value, digit 0 in [3:0].
REQ-010 SHALL have port count_bcd, output, 4*DIGITS bits: registered BCD count, digit 0 in [3:0].
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on full-range wrap.
REQ-012 SHALL have port an, output, DIGITS bits: active-low one-hot anode select.
REQ-013 SHALL have port port_cc, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.

Function
REQ-014 SHALL give load priority over counting: load=1 sets count_bcd from load_val on the next edge, clamping any nibble >9 to 9, with wrap=0.
REQ-015 SHALL count only when load=0, enable=1 and tick=1; count_bcd SHALL update on the edge sampling the tick (1-cycle latency).
REQ-016 SHALL count up with decimal ripple: a digit at 9 becomes 0 and carries into the next digit in the same cycle.
REQ-017 SHALL wrap all-9s to all-0s when counting up and SHALL assert wrap for exactly 1 cycle.
REQ-018 SHALL count down with decimal borrow: a digit at 0 becomes 9 and borrows from the next digit.
REQ-019 SHALL wrap all-0s to all-9s when counting down and SHALL assert wrap for exactly 1 cycle.
REQ-020 SHALL deassert wrap in every cycle without a wrap event.
REQ-021 SHALL treat a tick while enable=0 as no effect, and SHALL not queue it.
REQ-022 SHALL run a scan prescaler counting 0..SCAN_DIV-1 continuously, independent of enable.
REQ-023 SHALL, when the scan prescaler reaches terminal count, advance the scan index by 1 modulo DIGITS.
REQ-024 SHALL register an with only bit [index] low.
REQ-025 SHALL register port_cc as the 7-segment code of count_bcd digit [index], giving 1 cycle latency from index or count change.
REQ-026 SHALL use these port_cc codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-027 SHALL, with DIGITS=1, hold an=0 permanently and display digit 0.

Reset
REQ-028 SHALL, when reset=0 at a clock edge, set count_bcd=0, wrap=0, scan prescaler=0 and scan index=0.
REQ-029 SHALL, under reset, set an to bit 0 low and all other bits high, and port_cc=1000000.
REQ-030 SHALL give reset priority over load and tick; reset mid-scan or mid-count SHALL take effect in the same edge with no partial update.

Configuration
REQ-031 SHALL, when macro BCD_SCAN_BLANK_EN is defined, blank leading zeros: a digit above the most significant nonzero digit drives port_cc=1111111 while its anode still scans.
REQ-032 SHALL never blank digit 0, so value 0 shows a single "0".
REQ-033 SHALL, without BCD_SCAN_BLANK_EN, display all digits including leading zeros; reset values SHALL be identical in both builds.

Verification (DIGITS=2, SCAN_DIV=4)
REQ-034 SHALL check: reset=0 for 2 cycles -> count_bcd=0x00, wrap=0, an=2'b10, port_cc=1000000.
REQ-035 SHALL check: load 0x98, up, 2 ticks -> 0x99 then 0x00 with wrap high exactly on the 0x00 cycle.
REQ-036 SHALL check: load 0x00, up_dn=0, 1 tick -> 0x99 with wrap=1; a further tick -> 0x98 with wrap=0.
REQ-037 SHALL check: load 0x1F -> count_bcd=0x19; load and tick together -> the load value wins.
REQ-038 SHALL check: free-run scan -> an toggles 10/01 every 4 cycles; port_cc matches the digit under scan 1 cycle later.
REQ-039 SHALL check: count 0x05 with BCD_SCAN_BLANK_EN -> digit 1 shows 1111111; the same value without the macro -> digit 1 shows 1000000.
